spi_reg_bridge: RTL and testbench
=================================

// Module: spi_reg_bridge
// PURPOSE
//  SPI target-side responder: turns master frames into register-bus reads/writes.
//  - Byte 0 is a command byte:
//    - MSB = R/W (1 = read).
//    - Remaining bits = start address.
//  - Following bytes are write data (MOSI) or read data (MISO), with address auto-increment.
//  - Sits behind the SPI pins and in front of any peripheral register file.
//  - Runs on the system clock; SCLK is oversampled, never used as a clock.
// PARAMETERS
//  mode       2'b01  SPI mode; CPOL = mode[1], CPHA = mode[0].
//  bits_size  8      Bits per SPI word; address width is bits_size-1.
// PORTS
//  clk          in   1            system clock, all flops rising edge
//  reset_n      in   1            asynchronous active-low reset
//  SCLK         in   1            SPI clock from master (asynchronous to clk)
//  MOSI         in   1            master-out data, MSB first
//  ss           in   1            active-low target select
//  MISO         out  1            target-out data, MSB first; 0 while ss high
//  reg_addr     out  bits_size-1  register address for current access
//  reg_wr_en    out  1            1-clk write strobe
//  reg_wr_data  out  bits_size    write data, valid with reg_wr_en
//  reg_rd_en    out  1            1-clk read strobe
//  reg_rd_data  in   bits_size    read data, valid exactly 1 clk after reg_rd_en
//  busy         out  1            high while a frame is in progress (synced ss low)
// BEHAVIOUR
//  - Reset values: all outputs 0; state IDLE; shift registers, bit counter and address 0.
//  - Input sync: SCLK, MOSI and ss each pass through a 2-flop synchroniser.
//  - Edge detection:
//    - Edges are detected on the synchronised SCLK; detection latency is 3 clk.
//    - Supported SCLK period is >= 16 clk.
//    - Sample edge = leading edge if CPHA=0, trailing edge if CPHA=1.
//    - Shift edge = the other edge.
//    - Leading edge is rising when CPOL=0.
//  - MISO driving:
//    - Changes only on a detected shift edge, or on ss fall when CPHA=0.
//    - For CPHA=1 the first bit is driven on the first leading edge.
//  - FSM IDLE -> CMD: on synced ss fall. Bit counter = 0; MISO = 0 throughout CMD.
//  - FSM CMD:
//    - Shift MOSI on each sample edge.
//    - At bit bits_size-1: latch addr = cmd[bits_size-2:0].
//    - If cmd MSB = 0: go to WDATA.
//    - If cmd MSB = 1: pulse reg_rd_en with reg_addr = addr, then go to RDATA.
//  - FSM WDATA:
//    - After bits_size sample edges: pulse reg_wr_en for 1 clk with reg_addr = addr and reg_wr_data = shifted word.
//    - addr++ on the clk after the strobe.
//    - Remain in WDATA (burst).
//  - FSM RDATA:
//    - Capture reg_rd_data 1 clk after reg_rd_en into the tx shift register.
//    - Shift the tx register out MSB first; MOSI is ignored.
//    - At the last sample edge of each word: addr++ and pulse reg_rd_en again (prefetch).
//    - Remain in RDATA.
//  - Address auto-increment wraps modulo 2^(bits_size-1).
//  - ss rise in any state:
//    - Next clk: go to IDLE; busy = 0; MISO = 0; bit counter cleared.
//    - A partial word is discarded: no reg_wr_en is issued.
//    - A read prefetch already issued is harmless and is not cancelled.
//  - SCLK edges while ss is high are ignored.
//  - reg_wr_en and reg_rd_en are never high in the same clk.
//  - Each strobe is exactly 1 clk wide.
//  - Asynchronous reset mid-frame: return to reset values immediately; the frame is lost.
//    - After reset release the block waits for a fresh ss fall.
//    - A frame already in progress (ss low at release) is ignored until ss rises.
// STRUCTURE
//  - Shared header spi_defs.vh:
//    - Mode decode macros (CPOL/CPHA bit index).
//    - State encodings IDLE/CMD/WDATA/RDATA.
//    - R/W bit position.
//  - Sub-module spi_sclk_sync:
//    - 2-flop synchronisers for SCLK, MOSI and ss.
//    - Outputs: sample_pulse, shift_pulse, ss_fall, ss_rise, mosi_s.
//    - Parameterised by mode.
//  - Top level: FSM, bit counter, rx/tx shift registers, address counter.
// TESTING
//  - Bench master model drives SCLK = clk/16.
//  - Bench register model returns reg_rd_data = addr + 8'h40.
//  - Test 1, write, mode 01: bytes 8'h05, 8'hA5 -> one reg_wr_en with addr 7'h05, data 8'hA5; no reg_rd_en.
//  - Test 2, burst write with wrap: bytes 8'h7F, 8'h11, 8'h22 -> writes (7'h7F, 8'h11) then (7'h00, 8'h22).
//  - Test 3, burst read: bytes 8'h83, 8'hxx, 8'hxx -> MISO words 8'h43 then 8'h44; master sees 8'h00 during the cmd byte.
//  - Test 4, abort: ss rises after 5 bits of data byte -> no reg_wr_en, busy = 0 in <= 3 clk; next frame 8'h01, 8'h5A writes correctly.
//  - Test 5, reset mid-frame: reset_n low during RDATA -> all outputs 0 at once; a subsequent full frame behaves normally.
//  - Test 6, all modes: repeat tests 1 and 3 for mode = 00, 01, 10, 11 -> identical register-bus transactions and MISO words.

Source files
------------

// File: rtl/spi_reg_bridge_pkg.sv
// spi_reg_bridge_pkg: shared FSM state encoding, mode bit positions and command field helper
package spi_reg_bridge_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_WDATA, ST_RDATA} state_t;
    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;
    function automatic int rw_bit(input int bits_size);
        return bits_size - 1;
    endfunction
endpackage

// File: rtl/spi_reg_bridge_sclk_sync.sv
// spi_reg_bridge_sclk_sync: synchronises SCLK/MOSI/ss into clk and derives mode-dependent edge strobes
//   clk, reset_n            system clock, async active-low reset
//   sclk, mosi, ss          raw SPI pins
//   sample_pulse            1-clk strobe on the SPI sample edge (only while synced ss low)
//   shift_pulse             1-clk strobe on the SPI shift edge (only while synced ss low)
//   ss_fall, ss_rise        1-clk strobes on synced ss transitions
//   mosi_s                  synchronised MOSI, aligned with the edge strobes
module spi_reg_bridge_sclk_sync
    import spi_reg_bridge_pkg::*;
#(
    parameter logic [1:0] mode = 2'b01
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sclk,
    input  logic mosi,
    input  logic ss,
    output logic sample_pulse,
    output logic shift_pulse,
    output logic ss_fall,
    output logic ss_rise,
    output logic mosi_s
);
    logic [2:0] sclk_q;
    logic [2:0] ss_q;
    logic [1:0] mosi_q;
    logic rise, fall, lead, trail, active;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_q <= '0;
            ss_q   <= '0;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            ss_q   <= {ss_q[1:0], ss};
            mosi_q <= {mosi_q[0], mosi};
        end
    end
    // ss history resets low so a frame already running at reset release never produces a fall
    always_comb begin
        rise         = sclk_q[1] & ~sclk_q[2];
        fall         = ~sclk_q[1] & sclk_q[2];
        lead         = mode[CPOL_BIT] ? fall : rise;
        trail        = mode[CPOL_BIT] ? rise : fall;
        active       = ~ss_q[1];
        sample_pulse = active & (mode[CPHA_BIT] ? trail : lead);
        shift_pulse  = active & (mode[CPHA_BIT] ? lead : trail);
        ss_fall      = ~ss_q[1] & ss_q[2];
        ss_rise      = ss_q[1] & ~ss_q[2];
        mosi_s       = mosi_q[1];
    end
endmodule

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI target that turns command/data frames into register-bus reads and writes
//   clk, reset_n            system clock, async active-low reset
//   SCLK, MOSI, ss          SPI pins from master (oversampled, ss active low)
//   MISO                    read data to master, MSB first, 0 outside read data
//   reg_addr                register address, auto-increments through a burst
//   reg_wr_en, reg_wr_data  1-clk write strobe with data
//   reg_rd_en, reg_rd_data  1-clk read strobe; data expected 1 clk later
//   busy                    frame in progress
module spi_reg_bridge
    import spi_reg_bridge_pkg::*;
#(
    parameter logic [1:0] mode      = 2'b01,
    parameter int         bits_size = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 SCLK,
    input  logic                 MOSI,
    input  logic                 ss,
    output logic                 MISO,
    output logic [bits_size-2:0] reg_addr,
    output logic                 reg_wr_en,
    output logic [bits_size-1:0] reg_wr_data,
    output logic                 reg_rd_en,
    input  logic [bits_size-1:0] reg_rd_data,
    output logic                 busy
);
    localparam int CW = $clog2(bits_size);
    localparam int RW = rw_bit(bits_size);
    state_t state, state_next;
    logic sample_pulse, shift_pulse, ss_fall, ss_rise, mosi_s, last_bit, cap;
    logic [CW-1:0] bit_cnt;
    logic [bits_size-2:0] rx_sr, addr;
    logic [bits_size-1:0] tx_sr, word;

    spi_reg_bridge_sclk_sync #(.mode(mode)) u_sync (
        .clk(clk),
        .reset_n(reset_n),
        .sclk(SCLK),
        .mosi(MOSI),
        .ss(ss),
        .sample_pulse(sample_pulse),
        .shift_pulse(shift_pulse),
        .ss_fall(ss_fall),
        .ss_rise(ss_rise),
        .mosi_s(mosi_s)
    );

    assign reg_addr = addr;
    assign busy     = state != ST_IDLE;
    assign word     = {rx_sr, mosi_s};
    assign last_bit = bit_cnt == CW'(bits_size - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (ss_rise)
            state_next = ST_IDLE;
        else if (state == ST_IDLE && ss_fall)
            state_next = ST_CMD;
        else if (state == ST_CMD && sample_pulse && last_bit)
            state_next = word[RW] ? ST_RDATA : ST_WDATA;
    end

    // cap marks the clk where reg_rd_data answers the previous reg_rd_en
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt     <= '0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            addr        <= '0;
            cap         <= 1'b0;
            reg_wr_en   <= 1'b0;
            reg_wr_data <= '0;
            reg_rd_en   <= 1'b0;
            MISO        <= 1'b0;
        end else begin
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            cap       <= reg_rd_en;
            if (reg_wr_en) addr <= addr + 1'b1;
            if (ss_rise || ss_fall) begin
                bit_cnt <= '0;
            end else if (sample_pulse && state != ST_IDLE) begin
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
                if (state != ST_RDATA) rx_sr <= word[bits_size-2:0];
                if (last_bit && state == ST_CMD) begin
                    addr      <= word[bits_size-2:0];
                    reg_rd_en <= word[RW];
                end
                if (last_bit && state == ST_WDATA) begin
                    reg_wr_en   <= 1'b1;
                    reg_wr_data <= word;
                end
                if (last_bit && state == ST_RDATA) begin
                    addr      <= addr + 1'b1;
                    reg_rd_en <= 1'b1;
                end
            end
            // the load always lands several clks before the next shift edge at SCLK >= clk/16
            if (cap)
                tx_sr <= reg_rd_data;
            else if (shift_pulse && state == ST_RDATA)
                tx_sr <= {tx_sr[bits_size-2:0], 1'b0};
            MISO <= (ss_rise || ss_fall || state == ST_IDLE) ? 1'b0 :
                    shift_pulse ? (state == ST_RDATA && tx_sr[bits_size-1]) : MISO;
        end
    end
endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: directed bench driving one bridge per SPI mode through write, read, abort and reset frames
module tb_spi_reg_bridge;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic ss = 1'b1;
    int cur = 1;
    int passed = 0;
    int total = 0;
    int bad = 0;
    logic pw = 1'b0;
    logic pr = 1'b0;
    logic       miso_a    [4];
    logic [6:0] addr_a    [4];
    logic       wr_en_a   [4];
    logic       rd_en_a   [4];
    logic       busy_a    [4];
    logic [7:0] wr_data_a [4];
    logic [7:0] rd_data_a [4];
    logic [14:0] wq[$];
    logic [6:0]  rq[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_reg_bridge #(.mode(2'(g)), .bits_size(8)) dut (
            .clk(clk),
            .reset_n(reset_n),
            .SCLK(sclk),
            .MOSI(mosi),
            .ss(cur == g ? ss : 1'b1),
            .MISO(miso_a[g]),
            .reg_addr(addr_a[g]),
            .reg_wr_en(wr_en_a[g]),
            .reg_wr_data(wr_data_a[g]),
            .reg_rd_en(rd_en_a[g]),
            .reg_rd_data(rd_data_a[g]),
            .busy(busy_a[g])
        );
        always @(posedge clk) rd_data_a[g] <= {1'b0, addr_a[g]} + 8'h40;
    end

    always @(negedge clk) begin
        if (wr_en_a[cur]) wq.push_back({addr_a[cur], wr_data_a[cur]});
        if (rd_en_a[cur]) rq.push_back(addr_a[cur]);
        if ((wr_en_a[cur] && rd_en_a[cur]) || (wr_en_a[cur] && pw) || (rd_en_a[cur] && pr)) bad++;
        pw = wr_en_a[cur];
        pr = rd_en_a[cur];
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic set_mode(input int md);
        logic [1:0] m;
        m = 2'(md);
        @(negedge clk);
        cur = md;
        sclk = m[1];
        #320;
        wq.delete();
        rq.delete();
    endtask

    task automatic xfer(input logic [7:0] tx, input int nb, output logic [7:0] rx);
        logic [1:0] m;
        m = 2'(cur);
        rx = 8'h00;
        for (int i = 7; i > 7 - nb; i--) begin
            if (!m[0]) begin
                mosi = tx[i]; #80;
                rx[i] = miso_a[cur]; sclk = ~m[1]; #80;
                sclk = m[1];
            end else begin
                sclk = ~m[1]; mosi = tx[i]; #80;
                rx[i] = miso_a[cur]; sclk = m[1]; #80;
            end
        end
    endtask

    task automatic start_frame();
        ss = 1'b0;
        #160;
    endtask

    task automatic end_frame();
        #80;
        ss = 1'b1;
        #320;
    endtask

    task automatic test_reset();
        #1;
        total++; if (busy_a[cur] !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_a[cur]); else passed++;
        total++; if (miso_a[cur] !== 1'b0) $display("FAIL reset_miso got %b want 0", miso_a[cur]); else passed++;
        total++; if (addr_a[cur] !== 7'h00) $display("FAIL reset_addr got %h want 00", addr_a[cur]); else passed++;
        total++; if (wr_en_a[cur] !== 1'b0) $display("FAIL reset_wr_en got %b want 0", wr_en_a[cur]); else passed++;
        total++; if (rd_en_a[cur] !== 1'b0) $display("FAIL reset_rd_en got %b want 0", rd_en_a[cur]); else passed++;
        total++; if (wr_data_a[cur] !== 8'h00) $display("FAIL reset_wr_data got %h want 00", wr_data_a[cur]); else passed++;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_write(input int md);
        logic [7:0] rx;
        set_mode(md);
        start_frame();
        xfer(8'h05, 8, rx);
        total++; if (busy_a[cur] !== 1'b1) $display("FAIL write_busy_m%0d got %b want 1", md, busy_a[cur]); else passed++;
        xfer(8'hA5, 8, rx);
        end_frame();
        total++; if (wq.size() != 1) $display("FAIL write_count_m%0d got %0d want 1", md, wq.size()); else passed++;
        total++; if (wq.size() > 0 && wq[0] !== {7'h05, 8'hA5}) $display("FAIL write_txn_m%0d got %h want %h", md, wq[0], {7'h05, 8'hA5}); else passed++;
        total++; if (rq.size() != 0) $display("FAIL write_no_read_m%0d got %0d want 0", md, rq.size()); else passed++;
    endtask

    task automatic test_burst_write();
        logic [7:0] rx;
        set_mode(1);
        start_frame();
        xfer(8'h7F, 8, rx);
        xfer(8'h11, 8, rx);
        xfer(8'h22, 8, rx);
        end_frame();
        total++; if (wq.size() != 2) $display("FAIL burst_count got %0d want 2", wq.size()); else passed++;
        total++; if (wq.size() > 0 && wq[0] !== {7'h7F, 8'h11}) $display("FAIL burst_first got %h want %h", wq[0], {7'h7F, 8'h11}); else passed++;
        total++; if (wq.size() > 1 && wq[1] !== {7'h00, 8'h22}) $display("FAIL burst_wrap got %h want %h", wq[1], {7'h00, 8'h22}); else passed++;
    endtask

    task automatic test_read(input int md);
        logic [7:0] r0, r1, r2;
        set_mode(md);
        start_frame();
        xfer(8'h83, 8, r0);
        xfer(8'hFF, 8, r1);
        xfer(8'hFF, 8, r2);
        end_frame();
        total++; if (r0 !== 8'h00) $display("FAIL read_cmd_miso_m%0d got %h want 00", md, r0); else passed++;
        total++; if (r1 !== 8'h43) $display("FAIL read_word0_m%0d got %h want 43", md, r1); else passed++;
        total++; if (r2 !== 8'h44) $display("FAIL read_word1_m%0d got %h want 44", md, r2); else passed++;
        total++; if (rq.size() != 3 || rq[0] !== 7'h03) $display("FAIL read_strobes_m%0d got n=%0d first=%h want n=3 first=03", md, rq.size(), rq.size() > 0 ? rq[0] : 7'h00); else passed++;
        total++; if (wq.size() != 0 || miso_a[cur] !== 1'b0) $display("FAIL read_idle_m%0d got writes=%0d miso=%b want 0 0", md, wq.size(), miso_a[cur]); else passed++;
    endtask

    task automatic test_abort();
        logic [7:0] rx;
        set_mode(1);
        start_frame();
        xfer(8'h10, 8, rx);
        xfer(8'hFF, 5, rx);
        ss = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy_a[cur] !== 1'b0) $display("FAIL abort_busy got %b want 0", busy_a[cur]); else passed++;
        @(negedge clk);
        #320;
        total++; if (wq.size() != 0) $display("FAIL abort_no_write got %0d want 0", wq.size()); else passed++;
        start_frame();
        xfer(8'h01, 8, rx);
        xfer(8'h5A, 8, rx);
        end_frame();
        total++; if (wq.size() != 1 || wq[0] !== {7'h01, 8'h5A}) $display("FAIL abort_next_write got n=%0d %h want n=1 %h", wq.size(), wq.size() > 0 ? wq[0] : 15'h0, {7'h01, 8'h5A}); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] rx;
        set_mode(1);
        start_frame();
        xfer(8'h83, 8, rx);
        xfer(8'hFF, 3, rx);
        reset_n = 1'b0;
        #1;
        total++; if (busy_a[cur] !== 1'b0 || miso_a[cur] !== 1'b0) $display("FAIL midreset_busy_miso got %b%b want 00", busy_a[cur], miso_a[cur]); else passed++;
        total++; if ({addr_a[cur], wr_data_a[cur], wr_en_a[cur], rd_en_a[cur]} !== 17'h0) $display("FAIL midreset_bus got %h want 0", {addr_a[cur], wr_data_a[cur], wr_en_a[cur], rd_en_a[cur]}); else passed++;
        @(negedge clk);
        #40;
        reset_n = 1'b1;
        #40;
        wq.delete();
        rq.delete();
        xfer(8'h05, 8, rx);
        total++; if (busy_a[cur] !== 1'b0) $display("FAIL midreset_ignore_busy got %b want 0", busy_a[cur]); else passed++;
        total++; if (wq.size() + rq.size() != 0) $display("FAIL midreset_ignore_strobes got %0d want 0", wq.size() + rq.size()); else passed++;
        end_frame();
        start_frame();
        xfer(8'h0A, 8, rx);
        xfer(8'h3C, 8, rx);
        end_frame();
        total++; if (wq.size() != 1 || wq[0] !== {7'h0A, 8'h3C}) $display("FAIL midreset_recover got n=%0d %h want n=1 %h", wq.size(), wq.size() > 0 ? wq[0] : 15'h0, {7'h0A, 8'h3C}); else passed++;
    endtask

    task automatic test_all_modes();
        for (int md = 0; md < 4; md++) begin
            test_write(md);
            test_read(md);
        end
    endtask

    task automatic test_strobes();
        total++; if (bad != 0) $display("FAIL strobe_shape got %0d bad cycles want 0", bad); else passed++;
    endtask

    initial begin
        test_reset();
        test_write(1);
        test_burst_write();
        test_read(1);
        test_abort();
        test_reset_mid();
        test_all_modes();
        test_strobes();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
